// File: rtl/yin_sample_feeder.sv
// Decimates and DC-filters a raw ADC stream, buffers it in a small FIFO and feeds
// windows of samples to a pitch detector using a start/wait handshake.
`timescale 1ns/1ps
module yin_sample_feeder #(
  parameter int ADC_WIDTH    = 12,
  parameter int SIG_WIDTH    = 9,
  parameter int DECIM        = 4,
  parameter int DC_SHIFT     = 8,
  parameter int WARMUP       = 500,
  parameter int HOP          = 250,
  parameter int FIFO_DEPTH   = 16,
  parameter int WAIT_TIMEOUT = 65535
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [ADC_WIDTH-1:0]        adc_in,
  input  logic                        adc_valid_in,
  input  logic                        f_valid_in,
  output logic [SIG_WIDTH-1:0]        sig_out,
  output logic                        sig_valid_out,
  output logic                        start_computation_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
  output logic                        overflow_out,
  output logic                        timeout_out
);
  localparam int DSH  = $clog2(DECIM);
  localparam int SUMW = ADC_WIDTH + DSH;
  localparam int ACCW = ADC_WIDTH + DC_SHIFT + 2;
  localparam int OSH  = ADC_WIDTH - SIG_WIDTH;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int CMAX = (WARMUP > HOP) ? WARMUP : HOP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (SIG_WIDTH-1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (SIG_WIDTH-1)));

  typedef enum logic [1:0] {STREAM, START, WAIT} FeederState;

  logic signed [ADC_WIDTH-1:0] w_x;
  logic signed [ADC_WIDTH-1:0] w_d;
  logic signed [SUMW-1:0]      w_xExt;
  logic signed [SUMW-1:0]      w_sumNext;
  logic signed [ACCW-1:0]      w_dExt;
  logic signed [ACCW-1:0]      w_dc;
  logic signed [ACCW-1:0]      w_y;
  logic signed [ACCW-1:0]      w_yShift;
  logic signed [SIG_WIDTH-1:0] w_sat;
  logic                        w_decimDone;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_drop;
  logic [SIG_WIDTH-1:0]        w_rdData;

  logic signed [SUMW-1:0]      r_acc;
  logic [DSH-1:0]              r_phase;
  logic signed [ACCW-1:0]      r_dcAcc;
  logic [SIG_WIDTH-1:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]               r_wrPtr;
  logic [PW-1:0]               r_rdPtr;
  logic [LW-1:0]               r_level;
  FeederState                  r_state;
  logic [CW-1:0]               r_sampleCnt;
  logic [CW-1:0]               r_target;
  logic [TW-1:0]               r_waitCnt;
  logic [SIG_WIDTH-1:0]        r_sigOut;
  logic                        r_sigValid;
  logic                        r_start;
  logic                        r_overflow;
  logic                        r_timeout;

  // Offset-binary to two's complement is just an MSB flip.
  assign w_x         = {~adc_in[ADC_WIDTH-1], adc_in[ADC_WIDTH-2:0]};
  assign w_xExt      = {{DSH{w_x[ADC_WIDTH-1]}}, w_x};
  assign w_sumNext   = r_acc + w_xExt;
  assign w_d         = ADC_WIDTH'(w_sumNext >>> DSH);
  assign w_decimDone = adc_valid_in && (r_phase == DSH'(DECIM - 1));

  assign w_dExt   = {{(ACCW-ADC_WIDTH){w_d[ADC_WIDTH-1]}}, w_d};
  assign w_dc     = r_dcAcc >>> DC_SHIFT;
  assign w_y      = w_dExt - w_dc;
  assign w_yShift = w_y >>> OSH;

  always_comb begin
    w_sat = w_yShift[SIG_WIDTH-1:0];
    if (w_yShift > SAT_MAX) begin
      w_sat = SAT_MAX[SIG_WIDTH-1:0];
    end else if (w_yShift < SAT_MIN) begin
      w_sat = SAT_MIN[SIG_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_acc   <= '0;
      r_phase <= '0;
      r_dcAcc <= '0;
    end else if (adc_valid_in) begin
      if (w_decimDone) begin
        r_acc   <= '0;
        r_phase <= '0;
        r_dcAcc <= r_dcAcc + w_y;
      end else begin
        r_acc   <= w_sumNext;
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign w_full   = (r_level == LW'(FIFO_DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_pop    = (r_state == STREAM) && !w_empty;
  assign w_push   = w_decimDone && (!w_full || w_pop);
  assign w_drop   = w_decimDone && w_full && !w_pop;
  assign w_rdData = r_mem[r_rdPtr];

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_sat;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // The start pulse is issued on leaving START so it never overlaps the final pop's sig_valid.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= STREAM;
      r_sampleCnt <= '0;
      r_target    <= CW'(WARMUP);
      r_waitCnt   <= '0;
      r_sigOut    <= '0;
      r_sigValid  <= 1'b0;
      r_start     <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_sigValid <= 1'b0;
      r_start    <= 1'b0;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        STREAM: begin
          if (w_pop) begin
            r_sigOut   <= w_rdData;
            r_sigValid <= 1'b1;
            if (r_sampleCnt + CW'(1) == r_target) begin
              r_state     <= START;
              r_sampleCnt <= '0;
              r_target    <= CW'(HOP);
            end else begin
              r_sampleCnt <= r_sampleCnt + CW'(1);
            end
          end
        end
        START: begin
          r_start   <= 1'b1;
          r_waitCnt <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (f_valid_in) begin
            r_state <= STREAM;
          end else if (r_waitCnt == TW'(WAIT_TIMEOUT - 1)) begin
            r_state   <= STREAM;
            r_timeout <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + TW'(1);
          end
        end
        default: r_state <= STREAM;
      endcase
    end
  end

  assign sig_out               = r_sigOut;
  assign sig_valid_out         = r_sigValid;
  assign start_computation_out = r_start;
  assign fifo_level_out        = r_level;
  assign overflow_out          = r_overflow;
  assign timeout_out           = r_timeout;

endmodule
